// File: rtl/fifo_seq_pkg.sv
// Shared types and default constants for the FIFO bank sequencer.
package fifo_seq_pkg;

    // Default bank geometry
    localparam int unsigned DefNumFifo = 8;
    localparam int unsigned DefDepth   = 8;
    localparam int unsigned DefDw      = 8;

    // Sequencer phases: load the bank lane by lane, read it in lockstep, then signal completion
    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        DONE
    } seq_state_t;

    // Counter width that stays legal when the count range is a single value
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_bank_seq_if.sv
// Input byte stream and FIFO bank control/status bundle around the sequencer.
// master: the sequencer. slave: the host load path plus the FIFO bank.
interface fifo_bank_seq_if
    import fifo_seq_pkg::*;
#(
    parameter int unsigned NUM_FIFO = DefNumFifo,
    parameter int unsigned DW       = DefDw
);

    // Host byte stream
    logic                in_valid;
    logic [DW-1:0]       in_data;
    logic                in_ready;

    // FIFO bank side
    logic [NUM_FIFO-1:0] fifo_wren;
    logic [DW-1:0]       fifo_wdata;
    logic [NUM_FIFO-1:0] fifo_full;
    logic [NUM_FIFO-1:0] fifo_rden;
    logic [NUM_FIFO-1:0] fifo_empty;
    logic                drain_valid;

    modport master (
        input  in_valid,
        input  in_data,
        input  fifo_full,
        input  fifo_empty,
        output in_ready,
        output fifo_wren,
        output fifo_wdata,
        output fifo_rden,
        output drain_valid
    );

    modport slave (
        output in_valid,
        output in_data,
        output fifo_full,
        output fifo_empty,
        input  in_ready,
        input  fifo_wren,
        input  fifo_wdata,
        input  fifo_rden,
        input  drain_valid
    );

endinterface

// File: rtl/fifo_bank_seq.sv
// Sequencer for a bank of byte FIFOs: fills lane 0..NUM_FIFO-1 from one stream,
// DEPTH bytes each, then reads every lane in lockstep for DEPTH reads.
module fifo_bank_seq
    import fifo_seq_pkg::*;
#(
    parameter int unsigned NUM_FIFO = DefNumFifo,
    parameter int unsigned DEPTH    = DefDepth,
    parameter int unsigned DW       = DefDw
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    fifo_bank_seq_if.master bus,
    output logic            busy,
    output logic            done
);

    localparam int unsigned SW = cnt_width(NUM_FIFO);
    localparam int unsigned CW = cnt_width(DEPTH);
    localparam logic [SW-1:0] SelLast = SW'(NUM_FIFO - 1);
    localparam logic [CW-1:0] CntLast = CW'(DEPTH - 1);

    seq_state_t          state_q;
    logic [SW-1:0]       sel_q;
    logic [CW-1:0]       cnt_q;
    logic                drain_valid_q;

    logic                in_ready;
    logic                wr_hs;
    logic                rd_go;
    logic [NUM_FIFO-1:0] wren;
    logic [DW-1:0]       wdata;

    // Handshake and enable decode from current state, lane select and bank flags
    always_comb begin
        in_ready = (state_q == FILL) && !bus.fifo_full[sel_q];
        wr_hs    = in_ready && bus.in_valid;
        // All lanes must hold a byte so every lane advances together
        rd_go    = (state_q == DRAIN) && !(|bus.fifo_empty);
        wren     = '0;
        for (int i = 0; i < int'(NUM_FIFO); i++) begin
            wren[i] = wr_hs && (sel_q == SW'(i));
        end
        wdata    = bus.in_data;
    end

    assign bus.in_ready    = in_ready;
    assign bus.fifo_wren   = wren;
    assign bus.fifo_wdata  = wdata;
    assign bus.fifo_rden   = rd_go ? '1 : '0;
    assign bus.drain_valid = drain_valid_q;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);

    // Phase sequencing with lane select and per-lane byte / read counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FILL;
                        sel_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                FILL: begin
                    if (wr_hs) begin
                        if (cnt_q == CntLast) begin
                            cnt_q <= '0;
                            if (sel_q == SelLast) begin
                                // Lane select parks at 0 rather than wrapping past the bank
                                sel_q   <= '0;
                                state_q <= DRAIN;
                            end else begin
                                sel_q <= sel_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_go) begin
                        if (cnt_q == CntLast) begin
                            cnt_q   <= '0;
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // FIFO read data appears one cycle after rden, so valid trails the read by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_valid_q <= 1'b0;
        end else begin
            drain_valid_q <= rd_go;
        end
    end

endmodule

// File: tb/tb_fifo_bank_seq.sv
// Self-checking bench: sequencer plus a behavioural FIFO bank, checked cycle by cycle
// against a byte-count model of one fill+drain pass.
module tb_fifo_bank_seq;
    import fifo_seq_pkg::*;

    localparam int unsigned NF    = 2;
    localparam int unsigned D     = 8;
    localparam int unsigned W     = 8;
    localparam int unsigned TOTAL = NF * D;
    localparam int          LIMIT = 600;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [NF-1:0] force_full = '0;
    logic [NF-1:0] force_empty = '0;
    logic [NF-1:0] real_full;
    logic [NF-1:0] real_empty;

    int n_total = 0;
    int n_bad   = 0;

    fifo_bank_seq_if #(.NUM_FIFO(NF), .DW(W)) bus ();

    fifo_bank_seq #(.NUM_FIFO(NF), .DEPTH(D), .DW(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO bank: DEPTH entries per lane, o_data updates on the read edge
    logic [W-1:0] mem    [NF][D];
    logic [W-1:0] lane_q [NF];
    int unsigned  fcnt   [NF];
    int unsigned  wp     [NF];
    int unsigned  rp     [NF];

    always @(posedge clk) begin
        for (int i = 0; i < int'(NF); i++) begin
            if (rst) begin
                fcnt[i]   <= 0;
                wp[i]     <= 0;
                rp[i]     <= 0;
                lane_q[i] <= '0;
            end else begin
                if (bus.fifo_wren[i] && fcnt[i] < D) begin
                    mem[i][wp[i]] <= bus.fifo_wdata;
                    wp[i]         <= (wp[i] + 1) % D;
                end
                if (bus.fifo_rden[i] && fcnt[i] > 0) begin
                    lane_q[i] <= mem[i][rp[i]];
                    rp[i]     <= (rp[i] + 1) % D;
                end
                fcnt[i] <= fcnt[i] + ((bus.fifo_wren[i] && fcnt[i] < D) ? 1 : 0)
                                   - ((bus.fifo_rden[i] && fcnt[i] > 0) ? 1 : 0);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NF); i++) begin
            real_full[i]  = (fcnt[i] == D);
            real_empty[i] = (fcnt[i] == 0);
        end
    end

    assign bus.fifo_full  = real_full | force_full;
    assign bus.fifo_empty = real_empty | force_empty;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        check_eq({tag, "_wren"}, 32'(bus.fifo_wren), 0);
        check_eq({tag, "_rden"}, 32'(bus.fifo_rden), 0);
        check_eq({tag, "_dv"}, 32'(bus.drain_valid), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
    endtask

    // Hold reset for two cycles; check it took hold one edge in, and state after release
    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        force_full   = '0;
        force_empty  = '0;
        @(negedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_quiet("post_rst");
    endtask

    // One pass. vmode: 0 valid always, 1 valid every other cycle, 2 random.
    // abort_at > 0 stops driving once that many bytes were accepted.
    task automatic run_pass(input int vmode, input bit hold, input bit stall, input bit seqpat,
                            input int abort_at);
        logic [W-1:0]  pat [TOTAL];
        logic [NF-1:0] exp_wren;
        logic [NF-1:0] exp_rden;
        int  n = 0;
        int  r = 0;
        int  k = 0;
        int  cyc = 0;
        bit  started = 0;
        bit  prev_rden = 0;
        bit  fin = 0;
        bit  fill, drain, exp_ready, hs, exp_done, full_seen = 0;
        bit  nostall = (vmode == 0) && !stall;

        for (int i = 0; i < int'(TOTAL); i++) begin
            pat[i] = seqpat ? W'(i + 1) : W'($urandom);
        end

        while (!fin && cyc < LIMIT && !(abort_at > 0 && n == abort_at)) begin
            @(negedge clk);
            start = (cyc == 0) || hold;
            case (vmode)
                0:       bus.in_valid = 1'b1;
                1:       bus.in_valid = (cyc % 2 == 1);
                default: bus.in_valid = 1'($urandom % 2);
            endcase
            bus.in_data = (n < int'(TOTAL)) ? pat[n] : W'($urandom);
            force_full  = (stall && ($urandom % 4 == 0)) ? NF'($urandom) : '0;
            force_empty = (stall && ($urandom % 4 == 0)) ? NF'($urandom) : '0;
            #1;

            fill      = started && n < int'(TOTAL);
            drain     = started && n == int'(TOTAL) && r < int'(D);
            exp_ready = fill && !bus.fifo_full[n / D];
            hs        = exp_ready && bus.in_valid;
            exp_wren  = '0;
            if (hs) exp_wren[n / D] = 1'b1;
            exp_rden  = (drain && bus.fifo_empty == '0) ? '1 : '0;
            exp_done  = prev_rden && k == int'(D) - 1;

            check_eq("busy", 32'(busy), 32'(started));
            check_eq("in_ready", 32'(bus.in_ready), 32'(exp_ready));
            check_eq("wren", 32'(bus.fifo_wren), 32'(exp_wren));
            if (hs) check_eq("wdata", 32'(bus.fifo_wdata), 32'(pat[n]));
            check_eq("rden", 32'(bus.fifo_rden), 32'(exp_rden));
            check_eq("drain_valid", 32'(bus.drain_valid), 32'(prev_rden));
            check_eq("done", 32'(done), 32'(exp_done));
            if (drain && !full_seen) begin
                check_eq("bank_full", 32'(real_full), 32'({NF{1'b1}}));
                full_seen = 1;
            end
            if (prev_rden) begin
                for (int i = 0; i < int'(NF); i++) begin
                    check_eq("lane", 32'(lane_q[i]), 32'(pat[i * D + k]));
                end
                k++;
            end

            if (hs) n++;
            if (exp_rden != '0) r++;
            prev_rden = (exp_rden != '0);
            if (exp_done) fin = 1;
            started = 1;
            cyc++;
        end

        force_full  = '0;
        force_empty = '0;
        if (abort_at == 0) begin
            check_eq("pass_finished", 32'(fin), 1);
            if (nostall) check_eq("pass_cycles", 32'(cyc), 32'(1 + TOTAL + D + 1));
            // Back in IDLE: start (if still held) is only seen now
            @(negedge clk);
            start        = hold;
            bus.in_valid = 1'b0;
            #1;
            check_quiet("idle");
            if (hold) begin
                @(negedge clk);
                start = 1'b0;
                #1;
                check_eq("restart_busy", 32'(busy), 1);
                check_eq("restart_done", 32'(done), 0);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // 1: reset state
        do_reset();
        // 2: straight stream 0x01..0x10
        run_pass(0, 0, 0, 1, 0);
        // 3: valid toggling during fill
        run_pass(1, 0, 0, 1, 0);
        // 4: start held high for the whole pass, then abort the re-triggered pass
        run_pass(0, 1, 0, 1, 0);
        do_reset();
        // 5: reset after 5 bytes, then a clean pass must refill from lane 0
        run_pass(0, 0, 0, 1, 5);
        do_reset();
        run_pass(0, 0, 0, 0, 0);
        // 6: forced full / empty stalls with random data and valid
        for (int p = 0; p < 6; p++) begin
            run_pass(2, 0, 1, 0, 0);
        end
        run_pass(1, 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
